// File: rtl/tft_pkg.sv
// Shared TFT definitions: D/C encodings, panel command bytes and SPI FSM state encoding.
package tft_pkg;

    localparam logic       TFT_DC_CMD  = 1'b0;
    localparam logic       TFT_DC_DATA = 1'b1;

    localparam logic [7:0] TFT_CASET   = 8'h2A;
    localparam logic [7:0] TFT_PASET   = 8'h2B;
    localparam logic [7:0] TFT_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } tft_spi_state_t;

endpackage

// File: rtl/tft_spi_tx_if.sv
// Drawer-to-transmitter byte handshake: {dc,data} offered with transmit, held off by busy.
interface tft_spi_tx_if;

    logic       transmit;
    logic       dc;
    logic [7:0] data;
    logic       busy;

    modport master (output transmit, output dc, output data, input busy);
    modport slave  (input transmit, input dc, input data, output busy);

endinterface

// File: rtl/tft_spi_clkgen.sv
// SCK divider: one-cycle rise/fall strobes every CLK_DIV enabled cycles, alternating rise first.
module tft_spi_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CntW    = $clog2(CLK_DIV + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            tick;

    always_comb begin
        tick    = en && (cnt_q == CntLast);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        rise = tick & ~phase_q;
        fall = tick & phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel, MSB first, with CS and D/C pins.
// Optional one-entry holding register in front of the shifter: TFT_SPI_TX_PREFETCH_EN.
module tft_spi_tx
    import tft_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    tft_spi_tx_if.slave drw,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);

    localparam int unsigned     GapW    = $clog2(CS_GAP + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    tft_spi_state_t  state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      shreg_q, shreg_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            dc_q, dc_d;

    logic            load;
    logic [7:0]      ld_data;
    logic            ld_dc;
    logic            sck_rise, sck_fall;

`ifdef TFT_SPI_TX_PREFETCH_EN
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_dc_q, hold_dc_d;
    logic       accept;
    logic       shifter_free;

    // Shifter can take a byte while idle or in the last gap cycle, so no idle cycle between bytes.
    always_comb begin
        accept       = drw.transmit && !hold_valid_q;
        shifter_free = (state_q == StIdle) || ((state_q == StGap) && (gap_cnt_q == GapLast));
        load         = shifter_free && (hold_valid_q || accept);
        ld_data      = hold_valid_q ? hold_data_q : drw.data;
        ld_dc        = hold_valid_q ? hold_dc_q : drw.dc;
        hold_valid_d = hold_valid_q ? !load : (accept && !load);
        hold_data_d  = accept ? drw.data : hold_data_q;
        hold_dc_d    = accept ? drw.dc : hold_dc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_dc_q    <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_dc_q    <= hold_dc_d;
        end
    end

    assign drw.busy = hold_valid_q;
`else
    always_comb begin
        load    = drw.transmit && (state_q == StIdle);
        ld_data = drw.data;
        ld_dc   = drw.dc;
    end

    assign drw.busy = (state_q != StIdle);
`endif

    tft_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == StShift),
        .clr   (load),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        gap_cnt_d = gap_cnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        dc_d      = dc_q;

        case (state_q)
            StIdle: ;
            StShift: begin
                if (sck_rise) sck_d = 1'b1;
                if (sck_fall) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = StGap;
                        bit_cnt_d = 3'd0;
                        gap_cnt_d = '0;
                        cs_n_d    = 1'b1;
                        mosi_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        mosi_d    = shreg_q[6];
                        shreg_d   = {shreg_q[5:0], 1'b0};
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) state_d = StIdle;
                else                      gap_cnt_d = gap_cnt_q + GapW'(1);
            end
            default: state_d = StIdle;
        endcase

        // A load only happens from idle or the final gap cycle, so it overrides the case above.
        if (load) begin
            state_d   = StShift;
            bit_cnt_d = 3'd0;
            shreg_d   = ld_data[6:0];
            mosi_d    = ld_data[7];
            sck_d     = 1'b0;
            cs_n_d    = 1'b0;
            dc_d      = ld_dc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            gap_cnt_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            gap_cnt_q <= gap_cnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            dc_q      <= dc_d;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;
    assign spi_dc   = dc_q;

endmodule
